// File: rtl/or1200_vlx_pkg.sv
// Shared types and constants for the VLX store controller.
package or1200_vlx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VLX_ST = 2'd1,
        LSU_ST = 2'd2
    } vlx_state_e;

    localparam logic [7:0]  JPEG_STUFF_BYTE = 8'hFF;
    localparam logic [7:0]  JPEG_STUFF_PAD  = 8'h00;
    localparam logic [31:0] VLX_RST_ADDR    = 32'h0383c1d0;

endpackage

// File: rtl/or1200_vlx_byte_fifo.sv
// Byte FIFO accepting one or two bytes per cycle, popping at most one.
module or1200_vlx_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     push_two_i,
    input  logic [7:0]               din0_i,
    input  logic [7:0]               din1_i,
    input  logic                     pop_i,
    output logic [7:0]               head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q, wr_d, rd_d;
    logic [AW:0]   cnt_q, cnt_d, n_push, n_pop;

    always_comb begin
        n_push = '0;
        if (push_i) n_push = push_two_i ? (AW+1)'(2) : (AW+1)'(1);
        n_pop  = pop_i ? (AW+1)'(1) : '0;
        cnt_d  = cnt_q + n_push - n_pop;
        wr_d   = wr_q + n_push[AW-1:0];
        rd_d   = rd_q + n_pop[AW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; the count alone defines which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q] <= din0_i;
            if (push_two_i) mem_q[wr_q + AW'(1)] <= din1_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/or1200_vlx_store_ctrl.sv
// Arbitrates the single store port between the VLX byte stream and the LSU,
// with JPEG byte stuffing, output address counter and flush handshake.
module or1200_vlx_store_ctrl
    import or1200_vlx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter int          HI_WATER   = 3,
    parameter logic [31:0] RST_ADDR   = VLX_RST_ADDR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vlx_byte_valid_i,
    input  logic [7:0]  vlx_byte_i,
    output logic        vlx_byte_ready_o,
    input  logic        flush_i,
    output logic        flush_done_o,
    input  logic        base_addr_wr_i,
    input  logic [31:0] base_addr_i,
    output logic [31:0] vlx_addr_o,
    input  logic        lsu_req_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_dat_i,
    input  logic        lsu_byte_i,
    output logic        lsu_gnt_o,
    output logic        lsu_ack_o,
    output logic        st_req_o,
    output logic [31:0] st_addr_o,
    output logic [31:0] st_dat_o,
    output logic        st_byte_o,
    input  logic        ack_i,
    output logic        stall_cpu_o,
    output logic        busy_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    vlx_state_e    state_q;
    logic [31:0]   addr_q, addr_d;
    logic          flush_pend_q, flush_pend_d;
    logic [CW-1:0] count;
    logic [7:0]    head;
    logic          push, push_two, pop, fifo_empty, hi_water;

    // Ready needs room for a worst-case stuffed pair.
    assign vlx_byte_ready_o = (count <= CW'(FIFO_DEPTH - 2));
    assign push             = vlx_byte_valid_i & vlx_byte_ready_o;
    assign push_two         = (vlx_byte_i == JPEG_STUFF_BYTE);
    assign pop              = (state_q == VLX_ST) & ack_i;
    assign fifo_empty       = (count == '0);
    assign hi_water         = (count >= CW'(HI_WATER));

    or1200_vlx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .push_two_i (push_two),
        .din0_i     (vlx_byte_i),
        .din1_i     (JPEG_STUFF_PAD),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hi_water && !fifo_empty) state_q <= VLX_ST;
                    else if (lsu_req_i)          state_q <= LSU_ST;
                    else if (!fifo_empty)        state_q <= VLX_ST;
                end
                VLX_ST:  if (ack_i) state_q <= IDLE;
                LSU_ST:  if (ack_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        st_req_o  = 1'b0;
        st_addr_o = '0;
        st_dat_o  = '0;
        st_byte_o = 1'b0;
        lsu_gnt_o = 1'b0;
        lsu_ack_o = 1'b0;
        case (state_q)
            VLX_ST: begin
                st_req_o  = 1'b1;
                st_addr_o = addr_q;
                st_dat_o  = {24'b0, head};
                st_byte_o = 1'b1;
            end
            LSU_ST: begin
                st_req_o  = lsu_req_i;
                st_addr_o = lsu_addr_i;
                st_dat_o  = lsu_dat_i;
                st_byte_o = lsu_byte_i;
                lsu_gnt_o = 1'b1;
                lsu_ack_o = ack_i;
            end
            default: ;
        endcase
    end

    assign busy_o       = !fifo_empty | (state_q == VLX_ST) | flush_pend_q;
    assign flush_done_o = flush_pend_q & fifo_empty & (state_q == IDLE);
    assign stall_cpu_o  = ~vlx_byte_ready_o | flush_pend_q;
    assign vlx_addr_o   = addr_q;

    always_comb begin
        flush_pend_d = flush_done_o ? 1'b0 : (flush_pend_q | flush_i);
        addr_d       = addr_q;
        if (pop)                           addr_d = addr_q + 32'd1;
        else if (base_addr_wr_i && !busy_o) addr_d = base_addr_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q       <= RST_ADDR;
            flush_pend_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

endmodule

// File: tb/tb_or1200_vlx_store_ctrl.sv
// Randomized bench for or1200_vlx_store_ctrl against a queue-based reference model.
module tb_or1200_vlx_store_ctrl;
    localparam logic [31:0] RST_A = 32'h0383c1d0;

    logic        clk = 1'b0;
    logic        rst_i, vlx_byte_valid_i, flush_i, base_addr_wr_i;
    logic [7:0]  vlx_byte_i;
    logic [31:0] base_addr_i, lsu_addr_i, lsu_dat_i;
    logic        lsu_req_i, lsu_byte_i, ack_i;
    logic        vlx_byte_ready_o, flush_done_o, lsu_gnt_o, lsu_ack_o;
    logic        st_req_o, st_byte_o, stall_cpu_o, busy_o;
    logic [31:0] vlx_addr_o, st_addr_o, st_dat_o;

    always #5 clk = ~clk;

    or1200_vlx_store_ctrl dut (
        .clk_i(clk), .rst_i(rst_i),
        .vlx_byte_valid_i(vlx_byte_valid_i), .vlx_byte_i(vlx_byte_i),
        .vlx_byte_ready_o(vlx_byte_ready_o),
        .flush_i(flush_i), .flush_done_o(flush_done_o),
        .base_addr_wr_i(base_addr_wr_i), .base_addr_i(base_addr_i),
        .vlx_addr_o(vlx_addr_o),
        .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_dat_i(lsu_dat_i),
        .lsu_byte_i(lsu_byte_i), .lsu_gnt_o(lsu_gnt_o), .lsu_ack_o(lsu_ack_o),
        .st_req_o(st_req_o), .st_addr_o(st_addr_o), .st_dat_o(st_dat_o),
        .st_byte_o(st_byte_o), .ack_i(ack_i),
        .stall_cpu_o(stall_cpu_o), .busy_o(busy_o)
    );

    int nchk = 0, nerr = 0, ncyc = 0;
    bit chk_en = 0;

    // Reference model: bytes awaiting store, address, port owner (0 none, 1 VLX, 2 LSU).
    logic [7:0]  mq[$];
    logic [31:0] m_addr = RST_A;
    int          m_own = 0;
    bit          m_pend = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, ncyc, got, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit v, input logic [7:0] b, input bit fl,
                       input bit bw, input logic [31:0] ba, input bit lr,
                       input logic [31:0] la, input logic [31:0] ld, input bit lb,
                       input bit ak);
        int  sz;
        bit  rdy, busy, done;
        logic [31:0] e_addr, e_dat;
        @(negedge clk);
        rst_i = rst; vlx_byte_valid_i = v; vlx_byte_i = b; flush_i = fl;
        base_addr_wr_i = bw; base_addr_i = ba; lsu_req_i = lr; lsu_addr_i = la;
        lsu_dat_i = ld; lsu_byte_i = lb; ack_i = ak;
        #1;
        ncyc++;
        sz   = mq.size();
        rdy  = (4 - sz) >= 2;
        busy = (sz != 0) || (m_own == 1) || m_pend;
        done = m_pend && (sz == 0) && (m_own == 0);
        e_addr = (m_own == 1) ? m_addr : (m_own == 2) ? la : 32'h0;
        e_dat  = (m_own == 1 && sz > 0) ? {24'h0, mq[0]} : (m_own == 2) ? ld : 32'h0;
        if (chk_en) begin
            chk("ready",   32'(vlx_byte_ready_o), 32'(rdy));
            chk("stall",   32'(stall_cpu_o),      32'(!rdy || m_pend));
            chk("busy",    32'(busy_o),           32'(busy));
            chk("fdone",   32'(flush_done_o),     32'(done));
            chk("vaddr",   vlx_addr_o,            m_addr);
            chk("gnt",     32'(lsu_gnt_o),        32'(m_own == 2));
            chk("lack",    32'(lsu_ack_o),        32'(m_own == 2 && ak));
            chk("st_req",  32'(st_req_o),         32'(m_own == 1 || (m_own == 2 && lr)));
            chk("st_byte", 32'(st_byte_o),        32'(m_own == 1 || (m_own == 2 && lb)));
            chk("st_addr", st_addr_o,             e_addr);
            chk("st_dat",  st_dat_o,              e_dat);
        end
        if (rst) begin
            mq.delete(); m_addr = RST_A; m_own = 0; m_pend = 0;
        end else begin
            if (m_own == 1 && ak) begin
                void'(mq.pop_front()); m_addr = m_addr + 1; m_own = 0;
            end else if (m_own == 2 && ak) begin
                m_own = 0;
            end else if (m_own == 0) begin
                if (sz >= 3)     m_own = 1;
                else if (lr)     m_own = 2;
                else if (sz > 0) m_own = 1;
            end
            if (bw && !busy) m_addr = ba;
            if (v && rdy) begin
                mq.push_back(b);
                if (b == 8'hFF) mq.push_back(8'h00);
            end
            m_pend = done ? 1'b0 : (m_pend | fl);
        end
    endtask

    task automatic idle(input int n, input bit ak);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h0, 0, 0, 0, 0, 0, 0, 0, ak);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0);
        // Two plain bytes with zero-wait ack
        cyc(0, 1, 8'h12, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 8'h34, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(6, 1);
        chk("addr_after_two", vlx_addr_o, RST_A + 2);
        // Stuffing fills FIFO to 3 so ready drops
        cyc(0, 1, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 8'h77, 0, 0, 0, 0, 0, 0, 0, 0);
        // Delayed ack on the in-flight store
        idle(5, 0);
        idle(10, 1);
        // LSU wins at low count
        cyc(0, 1, 8'h21, 0, 0, 0, 1, 32'hA000_0004, 32'hDEAD_BEEF, 0, 0);
        cyc(0, 0, 8'h00, 0, 0, 0, 1, 32'hA000_0004, 32'hDEAD_BEEF, 0, 0);
        cyc(0, 1, 8'hFF, 0, 0, 0, 1, 32'hA000_0004, 32'hDEAD_BEEF, 0, 1);
        cyc(0, 0, 8'h00, 0, 0, 0, 1, 32'hA000_0008, 32'h1234_5678, 1, 0);
        cyc(0, 0, 8'h00, 0, 0, 0, 1, 32'hA000_0008, 32'h1234_5678, 1, 1);
        idle(8, 1);
        // Flush with queued bytes, then on empty, then base write while busy and idle
        cyc(0, 1, 8'h0A, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 8'h0B, 1, 1, 32'h1000, 0, 0, 0, 0, 0);
        cyc(0, 1, 8'h0C, 1, 1, 32'h1000, 0, 0, 0, 0, 0);
        idle(12, 1);
        cyc(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 0);
        cyc(0, 0, 8'h00, 0, 1, 32'h1000, 0, 0, 0, 0, 0);
        cyc(0, 1, 8'h5A, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 0);
        chk("base_store_addr", st_addr_o, 32'h1000);
        // Reset during a VLX store
        cyc(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 0);
        // Randomized phases with varying knobs: valid, FF, ack, lsu, flush, base wr, reset
        for (int ph = 0; ph < 4; ph++) begin
            int pv, pff, pak, plr, pfl, pbw, prs;
            pv  = (ph == 0) ? 70 : (ph == 1) ? 90 : (ph == 2) ? 40 : 60;
            pff = (ph == 1) ? 50 : 20;
            pak = (ph == 0) ? 90 : (ph == 2) ? 25 : 60;
            plr = (ph == 3) ? 60 : 20;
            pfl = 5;
            pbw = (ph == 2) ? 30 : 8;
            prs = (ph == 3) ? 2 : 0;
            for (int i = 0; i < 700; i++) begin
                logic [7:0] bb;
                bb = ($urandom_range(99) < pff) ? 8'hFF : 8'($urandom);
                cyc($urandom_range(99) < prs, $urandom_range(99) < pv, bb,
                    $urandom_range(99) < pfl, $urandom_range(99) < pbw, $urandom,
                    $urandom_range(99) < plr, $urandom, $urandom, 1'($urandom),
                    $urandom_range(99) < pak);
            end
        end
        idle(20, 1);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
